// File: rtl/rll_key_loader.sv
// rll_key_loader: serial key loader with even-parity check, failure lockout and zeroize.
// Ports: clk/rst (sync, active-high); load_start, zeroize control; bit_valid/bit_data/bit_ready
//   serial beats (key LSB first, then one parity bit); key_out/key_valid committed key;
//   load_err, locked, fail_count status. Latency: key_valid rises KEY_WIDTH+2 cycles after
//   load_start with gap-free beats. Backpressure: bit_ready is high only in SHIFT/PARITY;
//   the source may idle at any time with no timeout.
module rll_key_loader #(
  parameter int KEY_WIDTH = 32,
  parameter int MAX_FAIL  = 3,
  localparam int CW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1,
  localparam int FW = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  output logic                 bit_ready,
  input  logic                 zeroize,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 load_err,
  output logic                 locked,
  output logic [FW-1:0]        fail_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY,
    S_DONE,
    S_ERROR,
    S_LOCKED
  } state_t;

  state_t               state;
  logic [KEY_WIDTH-1:0] shadow;
  logic [CW-1:0]        cnt;
  logic                 beat;
  logic [FW-1:0]        fail_next;

  always_comb begin
    bit_ready = (state == S_SHIFT) || (state == S_PARITY);
  end

  assign beat      = bit_valid & bit_ready;
  assign fail_next = fail_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shadow     <= '0;
      cnt        <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      load_err   <= 1'b0;
      locked     <= 1'b0;
      fail_count <= '0;
    end else if (state != S_LOCKED && zeroize) begin
      // fail_count deliberately survives so zeroize cannot reset the lockout tally
      state     <= S_IDLE;
      shadow    <= '0;
      cnt       <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else if (state != S_LOCKED && load_start) begin
      // any beat presented this cycle is dropped: beat handling lives below
      state     <= S_SHIFT;
      shadow    <= '0;
      cnt       <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          if (beat) begin
            shadow[cnt] <= bit_data;
            if (cnt == CW'(KEY_WIDTH - 1)) begin
              state <= S_PARITY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (beat) begin
            if (((^shadow) ^ bit_data) == 1'b0) begin
              key_out    <= shadow;
              key_valid  <= 1'b1;
              fail_count <= '0;
              state      <= S_DONE;
            end else begin
              shadow     <= '0;
              fail_count <= fail_next;
              load_err   <= 1'b1;
              if (fail_next == FW'(MAX_FAIL)) begin
                locked <= 1'b1;
                state  <= S_LOCKED;
              end else begin
                state <= S_ERROR;
              end
            end
          end
        end
        S_LOCKED: begin
          // sticky until rst; count is already at MAX_FAIL
          locked    <= 1'b1;
          load_err  <= 1'b1;
          key_out   <= '0;
          key_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
